ram_cell: RTL and testbench



---
 rtl/ram_cell_if.sv | 14 +
 rtl/ram_cell.sv | 36 +++
 tb/tb_ram_cell.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_cell_if.sv
// Address/data bundle for ram_cell: shared address, write and read strobes, registered read data.
interface ram_cell_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) ();
    logic [ADDR_W-1:0] ad;
    logic              we;
    logic [DATA_W-1:0] wd;
    logic              re;
    logic [DATA_W-1:0] rd;

    modport master (output ad, we, wd, re, input rd);
    modport slave  (input ad, we, wd, re, output rd);
endinterface

// File: rtl/ram_cell.sv
// Single-port 2^ADDR_W x DATA_W synchronous RAM with registered read data and synchronous clear.
// RAM_CELL_WRITE_THROUGH_EN: same-edge write+read returns wd instead of the old word.
module ram_cell #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic       clock,
    input  logic       reset,
    ram_cell_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_nxt;

    // Port is single-address, so a concurrent write and read always hit the same word.
    always_comb begin
        rd_nxt = mem[bus.ad];
`ifdef RAM_CELL_WRITE_THROUGH_EN
        if (bus.we) rd_nxt = bus.wd;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_q <= '0;
        end else begin
            if (bus.we) mem[bus.ad] <= bus.wd;
            if (bus.re) rd_q <= rd_nxt;
        end
    end

    assign bus.rd = rd_q;
endmodule

// File: tb/tb_ram_cell.sv
// Directed bench for ram_cell; expected read data is queued at drive time and checked after the edge.
module tb_ram_cell;
    localparam int AW = 4;
    localparam int DW = 4;

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } sb_t;

    logic clock = 1'b0;
    logic reset;
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;

    ram_cell_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_cell #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // One clock edge; when chk is set the expected rd after this edge is queued and then checked.
    task automatic cyc(input logic rst, input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit chk, input logic [DW-1:0] exp, input string tag);
        sb_t e;
        reset  = rst;
        bus.we = w;
        bus.re = r;
        bus.ad = a;
        bus.wd = d;
        if (chk) begin
            e.tag = tag;
            e.exp = exp;
            sbq.push_back(e);
        end
        @(posedge clock);
        #1;
        if (chk) begin
            e = sbq.pop_front();
            checks++;
            assert (bus.rd === e.exp)
            else begin
                errors++;
                $error("FAIL %s: rd=%h expected=%h", e.tag, bus.rd, e.exp);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        reset  = 1'b1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.ad = '0;
        bus.wd = '0;

        // reset state
        cyc(1, 0, 0, 0, 0, 1, 4'h0, "reset_rd");

        // fill with F, reset, every word reads 0
        for (int i = 0; i < 16; i++) begin
            a = i[AW-1:0];
            cyc(0, 1, 0, a, 4'hF, 0, 4'h0, "");
        end
        cyc(0, 0, 1, 4'd9, 0, 1, 4'hF, "pre_reset_rd");
        cyc(1, 0, 0, 0, 0, 1, 4'h0, "reset_clears_rd");
        for (int i = 0; i < 16; i++) begin
            a = i[AW-1:0];
            cyc(0, 0, 1, a, 0, 1, 4'h0, "reset_clear_word");
        end

        // basic write then read
        cyc(0, 1, 0, 4'd2, 4'b1101, 0, 4'h0, "");
        cyc(0, 0, 1, 4'd2, 0, 1, 4'b1101, "basic_rd");

        // sweep ~addr
        for (int i = 0; i < 16; i++) begin
            a = i[AW-1:0];
            cyc(0, 1, 0, a, ~a, 0, 4'h0, "");
        end
        for (int i = 0; i < 16; i++) begin
            a = i[AW-1:0];
            cyc(0, 0, 1, a, 0, 1, ~a, "sweep_rd");
        end
        cyc(0, 0, 1, 4'd3, 0, 1, 4'hC, "sweep_rd3");
        cyc(0, 0, 0, 4'd5, 0, 1, 4'hC, "hold_re0_a");
        cyc(0, 1, 0, 4'd6, 4'h1, 1, 4'hC, "hold_re0_b");
        cyc(0, 0, 1, 4'd6, 0, 1, 4'h1, "write_over_sweep");

        // simultaneous read/write, same address
        cyc(0, 1, 0, 4'd5, 4'h3, 0, 4'h0, "");
`ifdef RAM_CELL_WRITE_THROUGH_EN
        cyc(0, 1, 1, 4'd5, 4'hA, 1, 4'hA, "rw_same_wt");
`else
        cyc(0, 1, 1, 4'd5, 4'hA, 1, 4'h3, "rw_same_rf");
`endif
        cyc(0, 0, 1, 4'd5, 0, 1, 4'hA, "rw_same_after");

        // reset beats write (addr 7 holds ~7 from the sweep)
        cyc(0, 0, 1, 4'd7, 0, 1, 4'h8, "pre_rst_w7");
        cyc(1, 1, 1, 4'd7, 4'h9, 1, 4'h0, "rst_vs_write_rd");
        cyc(0, 0, 1, 4'd7, 0, 1, 4'h0, "rst_vs_write_mem");
        cyc(0, 0, 1, 4'd2, 0, 1, 4'h0, "rst_clears_2");

        // independent addresses
        cyc(0, 1, 0, 4'd0, 4'hC, 0, 4'h0, "");
        cyc(0, 0, 1, 4'd0, 0, 1, 4'hC, "indep_rd0");
        cyc(0, 1, 0, 4'd1, 4'h6, 1, 4'hC, "indep_hold");
        cyc(0, 0, 1, 4'd1, 0, 1, 4'h6, "indep_rd1");
        cyc(0, 0, 1, 4'd0, 0, 1, 4'hC, "indep_rd0_again");

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
